// File: rtl/drbg_arb_pkg.sv
// Shared types and helpers for the DRBG stream arbiter.
package drbg_arb_pkg;

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_LOAD = 2'd1,
        S_XFER = 2'd2
    } arb_state_t;

    function automatic int unsigned words_per_block(input int unsigned word_bits);
        return 32'd128 / word_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker: searches strictly after the pointer, wrapping.
// The pointer moves to adv_idx when advance is strobed.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic [IDX_W-1:0] adv_idx,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // First requester after the pointer wins.
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        cand_s  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr_r) + i) % N_REQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                idx_s   = cand_s;
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Expand the winning index to a one-hot grant.
    always_comb begin
        gnt_any = found_s;
        gnt_idx = idx_s;
        if (found_s) begin
            gnt = N_REQ'(1) << idx_s;
        end else begin
            gnt = '0;
        end
    end

    // Pointer resets to the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= IDX_W'(N_REQ - 1);
        end else if (advance) begin
            ptr_r <= adv_idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/drbg_stream_arbiter.sv
// Splits the 128-bit DRBG stream into words for round-robin granted consumers.
// Leftover words are zeroized at the end of every grant.
module drbg_stream_arbiter
    import drbg_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WORD_BITS = 32,
    parameter int LEN_BITS  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      drbg_valid_i,
    output logic                      drbg_ready_o,
    input  logic [127:0]              drbg_data_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*LEN_BITS-1:0] req_len_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic                      rsp_valid_o,
    input  logic [N_REQ-1:0]          rsp_ready_i,
    output logic [WORD_BITS-1:0]      rsp_data_o,
    output logic                      rsp_last_o,
    output logic                      done_o,
    output logic                      busy_o,
    output logic [31:0]               words_served_o
);

    localparam int unsigned WPB   = words_per_block(WORD_BITS);
    localparam int          CNT_W = $clog2(WPB + 1);
    localparam int          IDX_W = $clog2(N_REQ);

    arb_state_t          state_r;
    logic [127:0]        buf_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [LEN_BITS-1:0] rem_r;
    logic [N_REQ-1:0]    gnt_r;
    logic [IDX_W-1:0]    gnt_idx_r;
    logic                done_r;
    logic                drbg_ready_r;
    logic                rsp_valid_r;
    logic                rsp_last_r;
    logic                busy_r;
    logic [31:0]         served_r;

    logic [N_REQ-1:0]    pick_gnt_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_any_s;
    logic [LEN_BITS-1:0] pick_len_s;
    logic                hs_s;
    logic                adv_s;
    logic [IDX_W-1:0]    adv_idx_s;
    logic [127:0]        buf_shift_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_i),
        .advance (adv_s),
        .adv_idx (adv_idx_s),
        .gnt     (pick_gnt_s),
        .gnt_idx (pick_idx_s),
        .gnt_any (pick_any_s)
    );

    // Handshake, length lookup and pointer advance (zero-length grant or last word).
    always_comb begin
        pick_len_s  = req_len_i[int'(pick_idx_s)*LEN_BITS +: LEN_BITS];
        hs_s        = rsp_valid_r && rsp_ready_i[gnt_idx_r];
        buf_shift_s = buf_r >> WORD_BITS;
        if (state_r == S_ARB && pick_any_s && pick_len_s == LEN_BITS'(0)) begin
            adv_s     = 1'b1;
            adv_idx_s = pick_idx_s;
        end else if (state_r == S_XFER && hs_s && rem_r == LEN_BITS'(1)) begin
            adv_s     = 1'b1;
            adv_idx_s = gnt_idx_r;
        end else begin
            adv_s     = 1'b0;
            adv_idx_s = gnt_idx_r;
        end
    end

    // Arbitration / load / transfer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_ARB;
            buf_r        <= 128'd0;
            cnt_r        <= '0;
            rem_r        <= '0;
            gnt_r        <= '0;
            gnt_idx_r    <= '0;
            done_r       <= 1'b0;
            drbg_ready_r <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            served_r     <= 32'd0;
        end else begin
            case (state_r)
                S_ARB: begin
                    done_r <= 1'b0;
                    if (pick_any_s) begin
                        gnt_r     <= pick_gnt_s;
                        gnt_idx_r <= pick_idx_s;
                        rem_r     <= pick_len_s;
                        if (pick_len_s == LEN_BITS'(0)) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r      <= S_LOAD;
                            drbg_ready_r <= 1'b1;
                            busy_r       <= 1'b1;
                        end
                    end else begin
                        gnt_r <= '0;
                    end
                end
                S_LOAD: begin
                    done_r <= 1'b0;
                    if (drbg_valid_i) begin
                        buf_r        <= drbg_data_i;
                        cnt_r        <= CNT_W'(WPB);
                        state_r      <= S_XFER;
                        drbg_ready_r <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_last_r   <= (rem_r == LEN_BITS'(1));
                    end else begin
                        drbg_ready_r <= 1'b1;
                    end
                end
                S_XFER: begin
                    done_r <= 1'b0;
                    if (hs_s) begin
                        if (served_r != 32'hFFFF_FFFF) begin
                            served_r <= served_r + 32'd1;
                        end else begin
                            served_r <= served_r;
                        end
                        if (rem_r == LEN_BITS'(1)) begin
                            // Unused words of the block never leave the arbiter.
                            buf_r       <= 128'd0;
                            cnt_r       <= '0;
                            rem_r       <= '0;
                            done_r      <= 1'b1;
                            gnt_r       <= '0;
                            rsp_valid_r <= 1'b0;
                            rsp_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            state_r     <= S_ARB;
                        end else begin
                            buf_r <= buf_shift_s;
                            cnt_r <= cnt_r - CNT_W'(1);
                            rem_r <= rem_r - LEN_BITS'(1);
                            if (cnt_r == CNT_W'(1)) begin
                                state_r      <= S_LOAD;
                                rsp_valid_r  <= 1'b0;
                                rsp_last_r   <= 1'b0;
                                drbg_ready_r <= 1'b1;
                            end else begin
                                rsp_last_r <= (rem_r == LEN_BITS'(2));
                            end
                        end
                    end else begin
                        served_r <= served_r;
                    end
                end
                default: begin
                    state_r      <= S_ARB;
                    gnt_r        <= '0;
                    done_r       <= 1'b0;
                    drbg_ready_r <= 1'b0;
                    rsp_valid_r  <= 1'b0;
                    rsp_last_r   <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign drbg_ready_o   = drbg_ready_r;
    assign gnt_o          = gnt_r;
    assign rsp_valid_o    = rsp_valid_r;
    assign rsp_data_o     = buf_r[WORD_BITS-1:0];
    assign rsp_last_o     = rsp_last_r;
    assign done_o         = done_r;
    assign busy_o         = busy_r;
    assign words_served_o = served_r;

endmodule
